// File: rtl/ones_acc_if.sv
// Handshake/result bundle for the ones_acc frame accumulator.
// master drives start/in_valid/in_cnt; slave (the accumulator) returns ready, sum and status.
interface ones_acc_if #(
    parameter int ACC_W = 8
);
    logic             start;
    logic             in_valid;
    logic [2:0]       in_cnt;
    logic             in_ready;
    logic [ACC_W-1:0] sum;
    logic             sum_valid;
    logic             busy;
    logic             ovf;

    modport master (
        output start, in_valid, in_cnt,
        input  in_ready, sum, sum_valid, busy, ovf
    );

    modport slave (
        input  start, in_valid, in_cnt,
        output in_ready, sum, sum_valid, busy, ovf
    );
endinterface

// File: rtl/ones_acc.sv
// Frame accumulator: sums FRAME_LEN per-word ones counts into an ACC_W-bit total with sticky overflow.
// Define ONES_ACC_SAT_EN to saturate the sum on overflow instead of wrapping.
module ones_acc #(
    parameter int FRAME_LEN = 8,
    parameter int ACC_W     = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    ones_acc_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             sum_valid_q, sum_valid_d;
    logic             busy_q, busy_d;
    logic [ACC_W:0]   add_s;

    // One guard bit above the sum carries the true-sum overflow.
    assign add_s = {1'b0, sum_q} + {{(ACC_W - 2){1'b0}}, bus.in_cnt};

    // Next-state, datapath and status computation.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACC;
                    sum_d   = {ACC_W{1'b0}};
                    ovf_d   = 1'b0;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                if (bus.in_valid) begin
`ifdef ONES_ACC_SAT_EN
                    sum_d = add_s[ACC_W] ? {ACC_W{1'b1}} : add_s[ACC_W-1:0];
`else
                    sum_d = add_s[ACC_W-1:0];
`endif
                    ovf_d = ovf_q | add_s[ACC_W];
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        state_d = ACC;
                    end
                end else begin
                    state_d = ACC;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        sum_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State, datapath and registered status flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sum_q       <= {ACC_W{1'b0}};
            ovf_q       <= 1'b0;
            cnt_q       <= 8'd0;
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            sum_valid_q <= sum_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = (state_q == ACC);
    assign bus.sum       = sum_q;
    assign bus.ovf       = ovf_q;
    assign bus.sum_valid = sum_valid_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_ones_acc.sv
// Randomized self-checking bench for ones_acc: an 8-bit and a 5-bit accumulator share one stimulus
// stream and are compared against a frame-total reference model.
module tb_ones_acc;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    ones_acc_if #(.ACC_W(8)) a_if();
    ones_acc_if #(.ACC_W(5)) b_if();

    ones_acc #(.FRAME_LEN(8), .ACC_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    ones_acc #(.FRAME_LEN(8), .ACC_W(5)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: reported sum as a function of the true frame total.
    function automatic int exp_sum(input int total, input int w);
        int max_v;
        max_v = (1 << w) - 1;
`ifdef ONES_ACC_SAT_EN
        return (total > max_v) ? max_v : total;
`else
        return total % (1 << w);
`endif
    endfunction

    task automatic drive(input logic s, input logic v, input logic [2:0] c);
        a_if.start = s;  a_if.in_valid = v;  a_if.in_cnt = c;
        b_if.start = s;  b_if.in_valid = v;  b_if.in_cnt = c;
    endtask

    task automatic check_outs(input string tag, input int total,
                              input logic e_busy, input logic e_ready, input logic e_sv);
        check_val({tag, ".sum8"},  32'(a_if.sum),       32'(exp_sum(total, 8)));
        check_val({tag, ".ovf8"},  32'(a_if.ovf),       32'(total > 255));
        check_val({tag, ".sum5"},  32'(b_if.sum),       32'(exp_sum(total, 5)));
        check_val({tag, ".ovf5"},  32'(b_if.ovf),       32'(total > 31));
        check_val({tag, ".busy8"}, 32'(a_if.busy),      32'(e_busy));
        check_val({tag, ".busy5"}, 32'(b_if.busy),      32'(e_busy));
        check_val({tag, ".rdy8"},  32'(a_if.in_ready),  32'(e_ready));
        check_val({tag, ".rdy5"},  32'(b_if.in_ready),  32'(e_ready));
        check_val({tag, ".sv8"},   32'(a_if.sum_valid), 32'(e_sv));
        check_val({tag, ".sv5"},   32'(b_if.sum_valid), 32'(e_sv));
    endtask

    // Entered and left at a negedge. gap_mode: 0 none, 1 one idle cycle between words, 2 random.
    task automatic run_frame(input string tag, input int words[$], input int gap_mode, input bit glitch);
        int total;
        int gaps;
        total = 0;
        drive(1'b1, 1'b0, 3'd0);
        @(negedge clk);
        check_outs({tag, ".start"}, 0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < words.size(); i++) begin
            gaps = (gap_mode == 1 && i > 0) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gaps; g++) begin
                drive(1'b0, 1'b0, 3'($urandom));
                @(negedge clk);
                check_outs({tag, ".gap"}, total, 1'b1, 1'b1, 1'b0);
            end
            drive(glitch && (i == 4), 1'b1, 3'(words[i]));
            total += words[i];
            @(negedge clk);
            if (i == words.size() - 1) begin
                check_outs({tag, ".done"}, total, 1'b1, 1'b0, 1'b1);
            end else begin
                check_outs({tag, ".acc"}, total, 1'b1, 1'b1, 1'b0);
            end
        end
        // Extra word and start during DONE must both be ignored.
        drive(glitch, 1'b1, 3'($urandom));
        @(negedge clk);
        check_outs({tag, ".idle"}, total, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'($urandom), 3'($urandom));
            @(negedge clk);
            check_outs({tag, ".hold"}, total, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int q[$];
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 3'd0);
        #3;
        check_outs("por", 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        q = '{6, 6, 6, 6, 6, 6, 6, 6};
        run_frame("b2b6", q, 0, 1'b0);
        q = '{1, 2, 3, 4, 5, 6, 0, 1};
        run_frame("gaps", q, 1, 1'b0);
        q = '{7, 7, 7, 7, 7, 7, 7, 7};
        run_frame("all7", q, 0, 1'b1);
        q = '{3, 3, 3, 3, 3, 3, 3, 3};
        run_frame("glitch", q, 2, 1'b1);

        // Mid-frame reset after 3 words of 5.
        drive(1'b1, 1'b0, 3'd0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 3'd5);
            @(negedge clk);
        end
        check_outs("pre_rst", 15, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 3'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("in_rst", 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        q = '{1, 1, 1, 1, 1, 1, 1, 1};
        run_frame("post_rst", q, 0, 1'b0);

        for (int f = 0; f < 12; f++) begin
            q = {};
            for (int i = 0; i < 8; i++) q.push_back(int'($urandom_range(0, 7)));
            run_frame("rand", q, 2, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ones_acc.md
ONES_ACC -- requirements
Module: ones_acc

Interface
- REQ-001 Parameter FRAME_LEN, default 8: number of accepted words per frame, legal range 1..255.
- REQ-002 Parameter ACC_W, default 8: width of the running sum, legal range 3..16.
- REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
- REQ-004 Port rst_n  input  1: asynchronous, active-low reset.
- REQ-005 Port start  input  1: request to begin a new frame.
- REQ-006 Port in_valid  input  1: in_cnt carries a valid per-word ones count.
- REQ-007 Port in_cnt  input  3: ones count of one 6-bit word from the upstream popcount stage.
- REQ-008 Port in_ready  output  1: block accepts in_cnt this cycle.
- REQ-009 Port sum  output  ACC_W: accumulated ones total of the current or last frame.
- REQ-010 Port sum_valid  output  1: single-cycle pulse, sum final.
- REQ-011 Port busy  output  1: frame in progress.
- REQ-012 Port ovf  output  1: sum exceeded 2^ACC_W-1 during the current or last frame.

Function
- REQ-013 FSM states SHALL be IDLE, ACC and DONE, encoded in a 2-bit state register.
- REQ-014 IDLE -> ACC on start=1; sum, ovf and the word counter SHALL clear on that edge.
- REQ-015 In ACC, in_ready SHALL be 1, combinationally; it SHALL be 0 in IDLE and DONE.
- REQ-016 A word SHALL be accepted only on a rising edge where in_valid=1 and in_ready=1.
- REQ-017 On accept, sum SHALL become sum + zero-extended in_cnt and the word counter SHALL increment.
- REQ-018 in_cnt=7 (out of range for 6-bit input) SHALL be added unchanged; no error flag.
- REQ-019 ACC -> DONE on the edge accepting word FRAME_LEN; no further words are accepted.
- REQ-020 In DONE, sum_valid SHALL be 1 for exactly one cycle; DONE -> IDLE unconditionally on the next edge.
- REQ-021 Latency: sum_valid SHALL assert in the cycle directly after the final accept.
- REQ-022 busy SHALL be 1 in ACC and DONE, 0 in IDLE.
- REQ-023 start SHALL be ignored in ACC and DONE.
- REQ-024 In IDLE, sum and ovf SHALL hold their last-frame values until the next start.
- REQ-025 Cycles with in_valid=0 in ACC SHALL leave sum and the counter unchanged (no timeout).
- REQ-026 ovf SHALL be sticky within a frame: set on any accept whose true sum exceeds 2^ACC_W-1.

Reset
- REQ-027 rst_n=0 SHALL asynchronously force state IDLE, sum=0, ovf=0, counter=0, sum_valid=0, busy=0, in_ready=0.
- REQ-028 Reset mid-frame SHALL discard the partial frame; no sum_valid pulse SHALL follow.
- REQ-029 After rst_n deasserts, the first start SHALL be honoured on the first rising edge.

Configuration
- REQ-030 Macro ONES_ACC_SAT_EN: when defined, overflowing adds SHALL saturate sum at 2^ACC_W-1.
- REQ-031 Without ONES_ACC_SAT_EN, sum SHALL wrap modulo 2^ACC_W.
- REQ-032 ovf behaviour SHALL be identical in both builds.

Verification
- REQ-033 Reset: hold rst_n=0 mid-clock -> all outputs 0 immediately, without waiting for a clock edge.
- REQ-034 Defaults: start, then 8 back-to-back words of in_cnt=6 -> sum=48 and ovf=0; sum_valid high one cycle after the 8th accept; busy low the cycle after.
- REQ-035 Gaps: deliver words 1,2,3,4,5,6,0,1 with in_valid low on alternate cycles -> sum=22 and the frame ends only after 8 accepts.
- REQ-036 Overflow: ACC_W=5 with 8 words of 6 -> sum=16 and ovf=1 without the macro; sum=31 and ovf=1 with ONES_ACC_SAT_EN.
- REQ-037 Mid-frame reset: apply reset after 3 words of 5 -> IDLE and sum=0; a following frame of 8 words of 1 gives sum=8.
- REQ-038 start pulsed in ACC after word 4 -> no clear; frame total unaffected; start pulsed in DONE -> ignored.
